seg_scan_ctrl: RTL and testbench

Scan controller that shares one active-low 7-segment bus and 4 anode lines among 4 stored hex digits. Digits are loaded one nibble at a time through a valid/ready write port with an auto-incrementing pointer. The block cycles through the digits with a blanking gap before each one to prevent ghosting, and is gated by a global clock enable. It sits between the nibble input/register logic and the board display pins, inside the top display path.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/hex_to_seg7.sv | 15 +
 rtl/seg_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the segment scan controller
//
// Purpose : FSM state encodings, blank/off output constants and the
//           hex-to-7-segment shape table (active-low, {g,f,e,d,c,b,a}).
// Ports   : none (package).
package seg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
  typedef enum logic       {READY, CLEAR}      wr_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Entry n of the packed array is the shape of hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decode
//
// Purpose : table lookup of one hex digit shape.
// Ports   : hex [3:0] in  - nibble to decode
//           seg [6:0] out - {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller
//
// Purpose : stores four hex digits written through a valid/ready port with an
//           auto-incrementing pointer, and scans them onto a shared active-low
//           segment bus with a blanking gap before each digit slot.
//           Optional macro SEG_SCAN_LZB_EN enables leading-zero blanking.
// Ports   : clk          in  - system clock, rising edge
//           rst_n        in  - asynchronous active-low reset
//           ce           in  - global enable; 0 blanks and halts scanning
//           clr          in  - starts a 4-cycle clear of all digits
//           wr_valid     in  - write request
//           wr_data[3:0] in  - hex nibble to store
//           wr_ready     out - write accepted when wr_valid && wr_ready
//           wr_ptr_o[1:0] out - next digit index to be written
//           an_o[3:0]    out - anode enables, active-low, bit i = digit i
//           seg_o[6:0]   out - {g,f,e,d,c,b,a}, active-low
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       clr,
  input  logic       wr_valid,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  output logic [1:0] wr_ptr_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST =
      CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  // With no blank gap every slot starts directly in SHOW.
  localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  // ---------------- digit storage and write FSM ----------------
  logic [3:0]  digit [4];
  wr_state_t   wr_state, wr_next;
  logic [1:0]  wr_ptr, ptr_next;
  logic [1:0]  clr_cnt, clr_cnt_next;
  logic        wr_en, clr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= READY;
      wr_ptr   <= 2'd0;
      clr_cnt  <= 2'd0;
    end else begin
      wr_state <= wr_next;
      wr_ptr   <= ptr_next;
      clr_cnt  <= clr_cnt_next;
    end
  end

  always_comb begin
    wr_next      = wr_state;
    ptr_next     = wr_ptr;
    clr_cnt_next = clr_cnt;
    wr_ready     = 1'b0;
    wr_en        = 1'b0;
    clr_en       = 1'b0;
    case (wr_state)
      READY: begin
        // clr wins over a same-cycle write by withholding ready.
        wr_ready = !clr;
        if (clr) begin
          wr_next      = CLEAR;
          ptr_next     = 2'd0;
          clr_cnt_next = 2'd0;
        end else if (wr_valid) begin
          wr_en    = 1'b1;
          ptr_next = wr_ptr + 2'd1;
        end
      end
      CLEAR: begin
        clr_en       = 1'b1;
        clr_cnt_next = clr_cnt + 2'd1;
        if (clr_cnt == 2'd3) wr_next = READY;
      end
      default: wr_next = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
    end else if (wr_en) begin
      digit[wr_ptr] <= wr_data;
    end else if (clr_en) begin
      digit[clr_cnt] <= 4'd0;
    end
  end

  assign wr_ptr_o = wr_ptr;

  // ---------------- scan FSM ----------------
  scan_state_t       scan_state, scan_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [1:0]        idx, idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_state <= IDLE;
      cnt        <= '0;
      idx        <= 2'd0;
    end else begin
      scan_state <= scan_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
    end
  end

  always_comb begin
    scan_next = scan_state;
    cnt_next  = cnt;
    idx_next  = idx;
    if (!ce) begin
      scan_next = IDLE;
      cnt_next  = '0;
      idx_next  = 2'd0;
    end else begin
      case (scan_state)
        IDLE: begin
          scan_next = SLOT_START;
          cnt_next  = '0;
          idx_next  = 2'd0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            scan_next = SHOW;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            scan_next = SLOT_START;
            cnt_next  = '0;
            idx_next  = idx + 2'd1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: scan_next = IDLE;
      endcase
    end
  end

  // ---------------- decode and registered outputs ----------------
  logic [6:0] dec_seg;
  logic       lead_blank;

  hex_to_seg7 u_dec (
    .hex (digit[idx]),
    .seg (dec_seg)
  );

  // Digit idx is a leading zero when it and every higher digit are zero;
  // digit 0 is never blanked so a value of 0 still shows one "0".
  always_comb begin
    lead_blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    case (idx)
      2'd3:    lead_blank = (digit[3] == 4'd0);
      2'd2:    lead_blank = ((digit[3] | digit[2]) == 4'd0);
      2'd1:    lead_blank = ((digit[3] | digit[2] | digit[1]) == 4'd0);
      default: lead_blank = 1'b0;
    endcase
`endif
  end

  // ce is looked at directly so dropping it blanks on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_BLANK;
    end else if (ce && scan_state == SHOW) begin
      an_o  <= ~(4'b0001 << idx);
      seg_o <= lead_blank ? SEG_BLANK : dec_seg;
    end else begin
      an_o  <= AN_OFF;
      seg_o <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce, clr, wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic [1:0] wr_ptr_o;
  logic [3:0] an_o;
  logic [6:0] seg_o;

  seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .clr      (clr),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_ptr_o (wr_ptr_o),
    .an_o     (an_o),
    .seg_o    (seg_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    int         len;   // 0 = run length not checked
  } disp_t;

  disp_t      disp_q [$];
  logic [1:0] ptr_q  [$];
  int         rdy_q  [$];

  int checks = 0;
  int failures = 0;

  logic       mon_on = 1'b0;
  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4];
  logic [1:0] exp_ptr = 2'd0;

  localparam logic [6:0] S_0 = 7'h40, S_1 = 7'h79, S_2 = 7'h24, S_3 = 7'h30;
  localparam logic [6:0] S_4 = 7'h19, S_5 = 7'h12, S_7 = 7'h78, S_OFF = 7'h7F;
`ifdef SEG_SCAN_LZB_EN
  localparam logic [6:0] S_LEAD0 = 7'h7F;
`else
  localparam logic [6:0] S_LEAD0 = 7'h40;
`endif

  // ---------------- display monitor: compares each completed output run ----
  logic [3:0] run_an;
  logic [6:0] run_seg;
  int         run_len;
  logic       run_act = 1'b0;

  task automatic close_run();
    disp_t e;
    if (disp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL disp_unexpected got an=%b seg=%b len=%0d", run_an, run_seg, run_len);
    end else begin
      e = disp_q.pop_front();
      checks++;
      if (e.an !== run_an || e.seg !== run_seg || (e.len != 0 && e.len != run_len)) begin
        failures++;
        $display("FAIL disp_run got an=%b seg=%b len=%0d exp an=%b seg=%b len=%0d",
                 run_an, run_seg, run_len, e.an, e.seg, e.len);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      if (!run_act) begin
        run_act = 1'b1; run_an = an_o; run_seg = seg_o; run_len = 1;
      end else if (an_o === run_an && seg_o === run_seg) begin
        run_len++;
      end else begin
        close_run();
        run_an = an_o; run_seg = seg_o; run_len = 1;
      end
    end else if (run_act) begin
      close_run();
      run_act = 1'b0;
    end
  end

  // ---------------- write-side monitors ----------------
  logic [1:0] last_ptr = 2'd0;
  int         low_len = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (wr_ptr_o !== last_ptr) begin
        checks++;
        if (ptr_q.size() == 0) begin
          failures++;
          $display("FAIL ptr_unexpected got %0d", wr_ptr_o);
        end else if (ptr_q[0] !== wr_ptr_o) begin
          failures++;
          $display("FAIL ptr_seq got %0d exp %0d", wr_ptr_o, ptr_q[0]);
        end
        if (ptr_q.size() != 0) void'(ptr_q.pop_front());
        last_ptr = wr_ptr_o;
      end
      if (wr_ready !== 1'b1) begin
        low_len++;
      end else if (low_len != 0) begin
        checks++;
        if (rdy_q.size() == 0) begin
          failures++;
          $display("FAIL rdy_unexpected low_len=%0d", low_len);
        end else begin
          if (rdy_q[0] != low_len) begin
            failures++;
            $display("FAIL rdy_low got %0d cycles exp %0d", low_len, rdy_q[0]);
          end
          void'(rdy_q.pop_front());
        end
        low_len = 0;
      end
    end
  end

  // ---------------- stimulus helpers (entered #1 after a posedge) ----------
  task automatic push_disp(input logic [3:0] an, input logic [6:0] seg, input int len);
    disp_t e;
    e.an = an; e.seg = seg; e.len = len;
    disp_q.push_back(e);
  endtask

  task automatic write_nib(input logic [3:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    exp_ptr  = exp_ptr + 2'd1;
    ptr_q.push_back(exp_ptr);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    checks++;
    if (disp_q.size() != 0 || ptr_q.size() != 0 || rdy_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s left disp=%0d ptr=%0d rdy=%0d exp all 0",
               name, disp_q.size(), ptr_q.size(), rdy_q.size());
      disp_q.delete(); ptr_q.delete(); rdy_q.delete();
    end
  endtask

  // From IDLE: 4 blank samples (ce just raised, IDLE, 2x BLANK), then
  // n slots of 6 shown + 2 blank.
  task automatic scan_slots(input int n, input string name);
    push_disp(4'hF, S_OFF, 4);
    for (int s = 0; s < n; s++) begin
      push_disp(an_tab[s % 4], exp_seg[s % 4], 6);
      push_disp(4'hF, S_OFF, 2);
    end
    ce = 1'b1; mon_on = 1'b1;
    repeat (8 * n + 4) @(posedge clk);
    #1 mon_on = 1'b0; ce = 1'b0;
    repeat (3) @(posedge clk);
    #1 drain(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ce = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = 4'd0;

    // 1. reset values, then idle blank with ce=0
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (an_o !== 4'hF)      begin failures++; $display("FAIL rst_an got %b exp 1111", an_o); end
    checks++; if (seg_o !== 7'h7F)    begin failures++; $display("FAIL rst_seg got %h exp 7f", seg_o); end
    checks++; if (wr_ready !== 1'b1)  begin failures++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
    checks++; if (wr_ptr_o !== 2'd0)  begin failures++; $display("FAIL rst_ptr got %0d exp 0", wr_ptr_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    push_disp(4'hF, S_OFF, 20);
    mon_on = 1'b1;
    repeat (20) @(posedge clk);
    #1 mon_on = 1'b0;
    @(posedge clk); #1 drain("idle");

    // 2./3. write 1,2,3,4; scan with wrap; drop ce during digit 2 of lap 2
    write_nib(4'd1); write_nib(4'd2); write_nib(4'd3); write_nib(4'd4);
    exp_seg = '{S_1, S_2, S_3, S_4};
    push_disp(4'hF, S_OFF, 4);
    for (int s = 0; s < 6; s++) begin
      push_disp(an_tab[s % 4], exp_seg[s % 4], 6);
      push_disp(4'hF, S_OFF, 2);
    end
    push_disp(an_tab[2], S_3, 3);     // cut short by ce=0
    push_disp(4'hF, S_OFF, 7);        // 4 with ce=0, then IDLE + 2x BLANK
    push_disp(an_tab[0], S_1, 6);     // restarts at digit 0
    push_disp(4'hF, S_OFF, 2);
    ce = 1'b1; mon_on = 1'b1;
    repeat (54) @(posedge clk);
    #1 ce = 1'b0;
    repeat (4) @(posedge clk);
    #1 ce = 1'b1;
    repeat (12) @(posedge clk);
    #1 mon_on = 1'b0; ce = 1'b0;
    repeat (3) @(posedge clk);
    #1 drain("scan");

    // 5. five writes: pointer 1,2,3,0,1 and digit 0 overwritten with 5
    write_nib(4'd1); write_nib(4'd2); write_nib(4'd3); write_nib(4'd4); write_nib(4'd5);
    exp_seg = '{S_5, S_2, S_3, S_4};
    scan_slots(4, "five");

    // 4. clr with a concurrent write of 9: write dropped, ready low for the
    //    clr cycle plus 4 clear cycles, pointer back to 0, all digits zero
    clr = 1'b1; wr_valid = 1'b1; wr_data = 4'd9;
    exp_ptr = 2'd0;
    ptr_q.push_back(2'd0);
    rdy_q.push_back(5);
    @(posedge clk); #1;
    clr = 1'b0; wr_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    exp_seg = '{S_0, S_LEAD0, S_LEAD0, S_LEAD0};
    scan_slots(4, "clear");

    // 6. digits {0,0,0,7}: leading-zero handling on digits 3..1
    write_nib(4'd7);
    exp_seg = '{S_7, S_LEAD0, S_LEAD0, S_LEAD0};
    scan_slots(4, "lzb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
